// File: rtl/plab5_mcore_test_mem_multipart.sv
// rtl/plab5_mcore_test_mem_multipart.sv - partitioned, domain-checked unified test memory
//
// Purpose: single req/resp test memory split into p_num_parts equal partitions.
// Each partition is owned by security domain (part % p_num_domains). Reads are
// allowed when the requester domain is >= the owner. Writes and AMOs are allowed
// only when the requester domain equals the owner. write_init skips the check.
// A denied access leaves the array untouched and answers with err=1, data=0.
// mem_clear starts a sequential clear that zeroes one word per cycle.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   mem_clear         pulse that starts clearing the whole array
//   clear_busy        high while the clear FSM is in CLEAR or DRAIN
//   memreq_*          request: val/rdy handshake, control, data, requester domain
//                     control = {type[2:0], opaque, addr, len}
//   memresp_*         response: val/rdy handshake, control, data, domain, err
//                     control = {type[2:0], opaque, len}
//
// Message types: 0 read, 1 write, 2 write_init, 3 amo_add, 4 amo_and, 5 amo_or.
// Unknown types are answered as denied. A write answers with data 0.
// An AMO answers with the old full word.

module plab5_mcore_test_mem_multipart #(
    parameter int p_mem_nbytes   = 1024,
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_num_parts    = 4,
    parameter int p_num_domains  = 2,
    localparam int c_dom_nbits   = (p_num_domains > 2) ? $clog2(p_num_domains) : 1,
    localparam int c_len_nbits   = (p_data_nbits > 8) ? $clog2(p_data_nbits / 8) : 1,
    localparam int c_req_nbits   = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits,
    localparam int c_resp_nbits  = 3 + p_opaque_nbits + c_len_nbits
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_clear,
    output logic                    clear_busy,
    input  logic                    memreq_val,
    output logic                    memreq_rdy,
    input  logic [c_req_nbits-1:0]  memreq_control,
    input  logic [p_data_nbits-1:0] memreq_data,
    input  logic [c_dom_nbits-1:0]  memreq_domain,
    output logic                    memresp_val,
    input  logic                    memresp_rdy,
    output logic [c_resp_nbits-1:0] memresp_control,
    output logic [p_data_nbits-1:0] memresp_data,
    output logic [c_dom_nbits-1:0]  memresp_domain,
    output logic                    memresp_err
);

    localparam int c_word_nbytes = p_data_nbits / 8;
    localparam int c_num_blocks  = p_mem_nbytes / c_word_nbytes;
    localparam int c_phys_nbits  = $clog2(p_mem_nbytes);
    localparam int c_part_nbits  = $clog2(p_num_parts);
    localparam int c_off_nbits   = c_len_nbits;
    localparam int c_idx_nbits   = c_phys_nbits - c_off_nbits;

    localparam logic [2:0] c_type_read  = 3'd0;
    localparam logic [2:0] c_type_write = 3'd1;
    localparam logic [2:0] c_type_init  = 3'd2;
    localparam logic [2:0] c_type_add   = 3'd3;
    localparam logic [2:0] c_type_and   = 3'd4;
    localparam logic [2:0] c_type_or    = 3'd5;

    localparam logic [c_idx_nbits-1:0] c_last_idx = c_idx_nbits'(c_num_blocks - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    logic [p_data_nbits-1:0] mem [0:c_num_blocks-1];

    // Input pipe queue (1 entry)
    logic                    pipe_full;
    logic [c_req_nbits-1:0]  pipe_ctrl;
    logic [p_data_nbits-1:0] pipe_data;
    logic [c_dom_nbits-1:0]  pipe_dom;

    // Output bypass queue (1 entry)
    logic                    out_full;
    logic [c_resp_nbits-1:0] out_ctrl;
    logic [p_data_nbits-1:0] out_data;
    logic [c_dom_nbits-1:0]  out_dom;
    logic                    out_err;

    logic pipe_enq;
    logic pipe_deq;
    logic out_deq;

    state_t                 state;
    state_t                 state_n;
    logic [c_idx_nbits-1:0] clr_idx;
    logic [c_idx_nbits-1:0] clr_idx_n;
    logic                   clr_we;

    // Decoded fields of the message sitting in the pipe queue
    logic [2:0]                req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [p_addr_nbits-1:0]   req_addr;
    logic [c_len_nbits-1:0]    req_len;
    logic [c_phys_nbits-1:0]   phys;
    logic [c_part_nbits-1:0]   part;
    logic [c_idx_nbits-1:0]    word_idx;
    logic [c_off_nbits-1:0]    offset;
    logic [31:0]               owner_ext;
    logic [31:0]               dom_ext;
    logic [31:0]               off_ext;
    logic [31:0]               nbytes;
    logic [p_data_nbits-1:0]   old_word;
    logic [p_data_nbits-1:0]   rd_shifted;
    logic [p_data_nbits-1:0]   wr_aligned;
    logic [c_word_nbytes-1:0]  len_mask;

    logic                      allowed;
    logic                      wr_en;
    logic [c_word_nbytes-1:0]  wr_be;
    logic [p_data_nbits-1:0]   wr_word;
    logic [p_data_nbits-1:0]   proc_data;
    logic [c_resp_nbits-1:0]   proc_ctrl;
    logic                      mem_we;

    logic unused_addr_bits;

    assign req_type   = pipe_ctrl[c_req_nbits-1 -: 3];
    assign req_opaque = pipe_ctrl[p_addr_nbits + c_len_nbits +: p_opaque_nbits];
    assign req_addr   = pipe_ctrl[c_len_nbits +: p_addr_nbits];
    assign req_len    = pipe_ctrl[c_len_nbits-1:0];

    assign phys      = req_addr[c_phys_nbits-1:0];
    assign part      = phys[c_phys_nbits-1 -: c_part_nbits];
    assign word_idx  = phys[c_phys_nbits-1:c_off_nbits];
    assign offset    = phys[c_off_nbits-1:0];
    assign owner_ext = 32'(part) % 32'(p_num_domains);
    assign dom_ext   = 32'(pipe_dom);
    assign off_ext   = 32'(offset);
    assign nbytes    = (req_len == '0) ? 32'(c_word_nbytes) : 32'(req_len);

    assign unused_addr_bits = ^req_addr;

    assign old_word   = mem[word_idx];
    assign rd_shifted = old_word >> {offset, 3'b000};
    assign wr_aligned = pipe_data << {offset, 3'b000};
    assign proc_ctrl  = {req_type, req_opaque, req_len};

    // Bytes offset..offset+len-1 of the word; anything past the word end drops out.
    always_comb begin
        len_mask = '0;
        for (int b = 0; b < c_word_nbytes; b++) begin
            len_mask[b] = (32'(b) >= off_ext) && (32'(b) < off_ext + nbytes);
        end
    end

    always_comb begin
        allowed   = 1'b0;
        wr_en     = 1'b0;
        wr_be     = '0;
        wr_word   = '0;
        proc_data = '0;
        case (req_type)
            c_type_read: begin
                allowed = (dom_ext >= owner_ext);
                if (allowed) proc_data = rd_shifted;
            end
            c_type_write, c_type_init: begin
                allowed = (req_type == c_type_init) || (dom_ext == owner_ext);
                wr_en   = allowed;
                wr_be   = len_mask;
                wr_word = wr_aligned;
            end
            c_type_add, c_type_and, c_type_or: begin
                allowed = (dom_ext == owner_ext);
                wr_en   = allowed;
                wr_be   = '1;
                if (req_type == c_type_add)      wr_word = old_word + pipe_data;
                else if (req_type == c_type_and) wr_word = old_word & pipe_data;
                else                             wr_word = old_word | pipe_data;
                if (allowed) proc_data = old_word;
            end
            default: allowed = 1'b0;
        endcase
    end

    // Handshakes. The pipe message is processed (and committed) in the cycle it
    // moves into the output stage; the output stage is bypassed when empty.
    assign pipe_deq    = pipe_full && !out_full;
    assign memreq_rdy  = !reset && (state == S_IDLE) && !mem_clear && (!pipe_full || pipe_deq);
    assign pipe_enq    = memreq_val && memreq_rdy;
    assign memresp_val = !reset && (out_full || pipe_full);
    assign out_deq     = memresp_val && memresp_rdy;
    assign mem_we      = pipe_deq && wr_en && !reset;

    always_comb begin
        memresp_control = '0;
        memresp_data    = '0;
        memresp_domain  = '0;
        memresp_err     = 1'b0;
        if (memresp_val) begin
            if (out_full) begin
                memresp_control = out_ctrl;
                memresp_data    = out_data;
                memresp_domain  = out_dom;
                memresp_err     = out_err;
            end else begin
                memresp_control = proc_ctrl;
                memresp_data    = proc_data;
                memresp_domain  = pipe_dom;
                memresp_err     = !allowed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_full <= 1'b0;
            pipe_ctrl <= '0;
            pipe_data <= '0;
            pipe_dom  <= '0;
        end else if (pipe_enq) begin
            pipe_full <= 1'b1;
            pipe_ctrl <= memreq_control;
            pipe_data <= memreq_data;
            pipe_dom  <= memreq_domain;
        end else if (pipe_deq) begin
            pipe_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_full <= 1'b0;
            out_ctrl <= '0;
            out_data <= '0;
            out_dom  <= '0;
            out_err  <= 1'b0;
        end else if (out_full) begin
            if (out_deq) out_full <= 1'b0;
        end else if (pipe_deq && !memresp_rdy) begin
            out_full <= 1'b1;
            out_ctrl <= proc_ctrl;
            out_data <= proc_data;
            out_dom  <= pipe_dom;
            out_err  <= !allowed;
        end
    end

    // Clear FSM. CLEAR holds off until the pipe queue is empty so any in-flight
    // request commits before the first word is zeroed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            clr_idx <= '0;
        end else begin
            state   <= state_n;
            clr_idx <= clr_idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_idx_n = clr_idx;
        clr_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_clear) begin
                    state_n   = S_CLEAR;
                    clr_idx_n = '0;
                end
            end
            S_CLEAR: begin
                if (!pipe_full) begin
                    clr_we = 1'b1;
                    if (clr_idx == c_last_idx) state_n = S_DRAIN;
                    else                       clr_idx_n = clr_idx + 1'b1;
                end
            end
            S_DRAIN: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign clear_busy = (state != S_IDLE);

    // Array has no reset: contents survive reset, including a partial clear.
    always_ff @(posedge clk) begin
        if (clr_we && !reset) begin
            mem[clr_idx] <= '0;
        end else if (mem_we) begin
            for (int b = 0; b < c_word_nbytes; b++) begin
                if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    a_req_val_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(memreq_val));
    a_resp_rdy_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(memresp_rdy));

endmodule
